raw_capture: RTL and testbench
==============================

Name: raw_capture

Overview:
- Front-end capture stage that sits directly upstream of the Bayer-to-RGB converter.
- Registers the camera's 12-bit parallel RAW bus together with its frame-valid and line-valid strobes.
- Gates capture to whole frames under start/stop control.
- Produces the pixel-valid strobe, column/row coordinates and frame count that the converter consumes.

Parameters:
COLUMN_WIDTH, 1280, active pixels per line; the column counter wraps after COLUMN_WIDTH-1.
FRAME_CNT_W, 32, width of the frame counter.

Ports:
iCLK  input  1  pixel clock.
iRST  input  1  asynchronous reset, active-low.
iDATA  input  12  RAW pixel from the sensor.
iFVAL  input  1  sensor frame valid.
iLVAL  input  1  sensor line valid.
iSTART  input  1  capture-enable request, single-cycle pulse or level.
iEND  input  1  capture-stop request, single-cycle pulse or level.
oDATA  output  12  registered RAW pixel.
oDVAL  output  1  oDATA is a captured pixel.
oX_Cont  output  11  column index of the pixel on oDATA.
oY_Cont  output  11  row index of the pixel on oDATA.
oFrame_Cont  output  FRAME_CNT_W  number of frames captured since reset.
oBUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (iRST=0, async): every output is 0, state is IDLE and the input registers are cleared.
- Pipeline stage 1: iDATA, iFVAL and iLVAL are registered as rD, rF and rL. The previous values rF_d and rL_d are kept for edge detection.
- Pipeline stage 2: oDATA <= rD. oDVAL <= rL & rF & frame_active.
- Latency: iDATA sampled at edge n appears on oDATA after edge n+1, i.e. 2 cycles.
- FSM states: IDLE, ARMED, CAPTURE, STOPPING. Transitions are evaluated on the registered strobes.
  - IDLE -> ARMED on iSTART.
  - ARMED -> CAPTURE on the rising edge of rF (rF & !rF_d). frame_active is set and oFrame_Cont increments in the same cycle.
  - ARMED -> IDLE on iEND.
  - CAPTURE -> STOPPING on iEND.
  - CAPTURE, new frame: on a rising edge of rF, stay in CAPTURE and increment oFrame_Cont.
  - CAPTURE or STOPPING, end of frame: on the falling edge of rF, frame_active is cleared. STOPPING goes to IDLE. CAPTURE stays in CAPTURE and waits for the next rF rise.
  - STOPPING: the current frame completes unchanged, and oDVAL continues until the rF fall.
- A start arriving mid-frame never produces a partial frame: capture begins at the next rF rise.
- iSTART and iEND in the same cycle: iEND wins, i.e. IDLE stays IDLE and ARMED goes to IDLE.
- iSTART is ignored in CAPTURE and STOPPING.
- Coordinates (oX_Cont, oY_Cont) are always the coordinates of the pixel currently on oDATA whenever oDVAL=1. The first pixel of a frame is (0,0).
  - After each emitted pixel: if X == COLUMN_WIDTH-1 then X <= 0 and Y++; otherwise X++.
  - Short line: on the falling edge of rL with X != 0, X <= 0 and Y++. This does not double-count a full-width line.
  - Y wraps modulo 2048.
  - At a rF rise and a rF fall, X and Y are cleared to 0.
- oFrame_Cont wraps modulo 2^FRAME_CNT_W and is not cleared by iEND.
- rL high while rF is low is ignored: no oDVAL and no counter movement.
- Any reset mid-frame returns to IDLE. After release, the block waits for iSTART and then a full rF rise.

Decomposition:
- Shared package holds the FSM state encoding (2-bit) and the coordinate width constant (11).
- One natural sub-module is raw_capture_xy_cnt: the X/Y counter with width wrap and short-line handling, driven by pixel-valid and line-end pulses.

Test Plan:
1. COLUMN_WIDTH=4. Pulse iSTART, then one frame of 2 lines × 4 px with data 1..8 -> oDVAL high 8 cycles, 2 cycles after input. Coordinates (0,0)..(3,0),(0,1)..(3,1), oDATA 1..8, oFrame_Cont=1.
2. iSTART asserted mid-frame (rF already high) -> no oDVAL for the rest of that frame. The next frame is captured from (0,0) and oFrame_Cont=1.
3. iEND pulsed at pixel (1,0) of frame 2 -> the frame completes (8 pixels). oBUSY falls after the rF fall, frame 3 yields no oDVAL, and oFrame_Cont stays 2.
4. Short line: 3 px then LVAL low, then a 4 px line -> coordinates (0,0)..(2,0), then (0,1)..(3,1).
5. iSTART and iEND in the same cycle from IDLE -> stays IDLE, oBUSY=0, no capture on the next frame.
6. iRST low at pixel (2,1) -> all outputs 0 immediately. After release, with no iSTART, subsequent frames yield no oDVAL.

Source files
------------

// File: rtl/raw_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raw_capture_pkg
// Purpose  : Shared definitions for the RAW capture front-end: the capture
//            FSM state encoding, the pixel width and the coordinate width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package raw_capture_pkg;

  localparam int PIX_W   = 12;   // sensor RAW bus width
  localparam int COORD_W = 11;   // column / row counter width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_STOPPING = 2'd3
  } cap_state_t;

endpackage : raw_capture_pkg
`default_nettype wire

// File: rtl/raw_capture_xy_cnt.sv
`default_nettype none
// ============================================================================
// Module   : raw_capture_xy_cnt
// Purpose  : Column/row counter for captured pixels. Advances after every
//            emitted pixel, wraps the column at COLUMN_WIDTH-1, and closes a
//            short line when line-valid falls before the column wrapped.
// Ports    : iCLK, iRST (async, active-low)
//            clear     - zero both coordinates (frame start / frame end)
//            pixel     - a pixel is currently being emitted at (x, y)
//            line_end  - falling edge of line-valid inside an active frame
//            x, y      - coordinates of the pixel currently emitted
// Revision : 1.0 - initial release
// ============================================================================
module raw_capture_xy_cnt
  import raw_capture_pkg::*;
#(
  parameter int COLUMN_WIDTH = 1280
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               clear,
  input  logic               pixel,
  input  logic               line_end,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COLUMN_WIDTH - 1);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (pixel) begin
      // The line-end pulse coincides with the last pixel of the line, so a
      // full-width line and a short line both advance the row exactly once.
      if (x == X_LAST || line_end) begin
        x <= '0;
        y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end else if (line_end && x != '0) begin
      x <= '0;
      y <= y + COORD_W'(1);
    end
  end

endmodule : raw_capture_xy_cnt
`default_nettype wire

// File: rtl/raw_capture.sv
`default_nettype none
// ============================================================================
// Module   : raw_capture
// Purpose  : Capture stage ahead of the Bayer-to-RGB converter. Registers the
//            sensor RAW bus and strobes, gates capture to whole frames under
//            start/stop control, and emits pixel-valid, coordinates and a
//            frame count.
// Ports    : iCLK, iRST (async, active-low)
//            iDATA/iFVAL/iLVAL  - sensor RAW pixel, frame valid, line valid
//            iSTART/iEND        - capture enable / stop requests
//            oDATA/oDVAL        - captured pixel and its valid strobe
//            oX_Cont/oY_Cont    - coordinates of the pixel on oDATA
//            oFrame_Cont        - frames captured since reset
//            oBUSY              - FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module raw_capture
  import raw_capture_pkg::*;
#(
  parameter int COLUMN_WIDTH = 1280,
  parameter int FRAME_CNT_W  = 32
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [PIX_W-1:0]       iDATA,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic                   iSTART,
  input  logic                   iEND,
  output logic [PIX_W-1:0]       oDATA,
  output logic                   oDVAL,
  output logic [COORD_W-1:0]     oX_Cont,
  output logic [COORD_W-1:0]     oY_Cont,
  output logic [FRAME_CNT_W-1:0] oFrame_Cont,
  output logic                   oBUSY
);

  // Stage-1 input registers and previous strobe values for edge detection
  logic [PIX_W-1:0] data_s1;
  logic             fval_s1, lval_s1, fval_d, lval_d;

  cap_state_t state, state_nxt;
  logic       frame_active, active_nxt, cnt_inc;

  logic fval_rise, fval_fall, line_end, pix_valid;

  assign fval_rise = fval_s1 & ~fval_d;
  assign fval_fall = ~fval_s1 & fval_d;
  // Line valid while frame valid is low never reaches the counters.
  assign line_end  = lval_d & ~lval_s1 & fval_s1 & frame_active;
  // Uses the next activity value so a line starting in the very cycle the
  // frame rise is seen still delivers its first pixel.
  assign pix_valid = lval_s1 & fval_s1 & active_nxt;
  assign oBUSY     = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_s1 <= '0;
      fval_s1 <= 1'b0;
      lval_s1 <= 1'b0;
      fval_d  <= 1'b0;
      lval_d  <= 1'b0;
    end else begin
      data_s1 <= iDATA;
      fval_s1 <= iFVAL;
      lval_s1 <= iLVAL;
      fval_d  <= fval_s1;
      lval_d  <= lval_s1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= ST_IDLE;
      frame_active <= 1'b0;
      oDATA        <= '0;
      oDVAL        <= 1'b0;
      oFrame_Cont  <= '0;
    end else begin
      state        <= state_nxt;
      frame_active <= active_nxt;
      oDATA        <= data_s1;
      oDVAL        <= pix_valid;
      if (cnt_inc) begin
        oFrame_Cont <= oFrame_Cont + FRAME_CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    active_nxt = frame_active;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A simultaneous stop request cancels the start.
        if (iSTART && !iEND) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (iEND) begin
          state_nxt = ST_IDLE;
        end else if (fval_rise) begin
          state_nxt  = ST_CAPTURE;
          active_nxt = 1'b1;
          cnt_inc    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (fval_fall) begin
          active_nxt = 1'b0;
          if (iEND) begin
            state_nxt = ST_IDLE;
          end
        end else if (fval_rise) begin
          active_nxt = 1'b1;
          cnt_inc    = 1'b1;
          if (iEND) begin
            state_nxt = ST_STOPPING;
          end
        end else if (iEND) begin
          // Between frames there is nothing left to finish.
          state_nxt = frame_active ? ST_STOPPING : ST_IDLE;
        end
      end
      ST_STOPPING: begin
        if (fval_fall) begin
          active_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        active_nxt = 1'b0;
      end
    endcase
  end

  raw_capture_xy_cnt #(
    .COLUMN_WIDTH (COLUMN_WIDTH)
  ) u_xy_cnt (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .clear    (fval_rise | fval_fall),
    .pixel    (oDVAL),
    .line_end (line_end),
    .x        (oX_Cont),
    .y        (oY_Cont)
  );

endmodule : raw_capture
`default_nettype wire

// File: tb/tb_raw_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_capture
// Purpose  : Directed self-checking bench for raw_capture with a 4-pixel
//            line width: whole-frame capture, mid-frame start, stop request,
//            short line, start+stop collision and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raw_capture;
  import raw_capture_pkg::*;

  localparam int COLUMN_WIDTH = 4;
  localparam int FRAME_CNT_W  = 32;

  logic                   iCLK, iRST;
  logic [PIX_W-1:0]       iDATA;
  logic                   iFVAL, iLVAL, iSTART, iEND;
  logic [PIX_W-1:0]       oDATA;
  logic                   oDVAL;
  logic [COORD_W-1:0]     oX_Cont, oY_Cont;
  logic [FRAME_CNT_W-1:0] oFrame_Cont;
  logic                   oBUSY;

  raw_capture #(
    .COLUMN_WIDTH (COLUMN_WIDTH),
    .FRAME_CNT_W  (FRAME_CNT_W)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oBUSY       (oBUSY)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Stimulus record (what the bench drove) and output record (what appeared)
  int in_data[$], in_cyc[$], exp_x[$], exp_y[$];
  int out_data[$], out_cyc[$], out_x[$], out_y[$];

  always @(negedge iCLK) begin
    if (oDVAL === 1'b1) begin
      out_data.push_back(int'(oDATA));
      out_x.push_back(int'(oX_Cont));
      out_y.push_back(int'(oY_Cont));
      out_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;
  int pix_val = 1;
  int frame_idx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    in_data.delete(); in_cyc.delete(); exp_x.delete(); exp_y.delete();
    out_data.delete(); out_cyc.delete(); out_x.delete(); out_y.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0;
    idle(2);
    iRST = 1'b1;
    idle(1);
  endtask

  task automatic pulse_start();
    @(negedge iCLK) iSTART = 1'b1;
    @(negedge iCLK) iSTART = 1'b0;
  endtask

  // One line of len pixels; iEND is raised with frame pixel number end_at.
  task automatic send_line(input int len, input int line, input int end_at);
    for (int i = 0; i < len; i++) begin
      @(negedge iCLK);
      iLVAL = 1'b1;
      iDATA = PIX_W'(pix_val);
      iEND  = (frame_idx == end_at);
      in_data.push_back(pix_val);
      in_cyc.push_back(cyc);
      exp_x.push_back(i);
      exp_y.push_back(line);
      pix_val++;
      frame_idx++;
    end
    @(negedge iCLK);
    iLVAL = 1'b0; iEND = 1'b0; iDATA = '0;
    idle(1);
  endtask

  task automatic send_frame(input int l0, input int l1, input int end_at);
    frame_idx = 0;
    @(negedge iCLK) iFVAL = 1'b1;
    idle(2);
    send_line(l0, 0, end_at);
    send_line(l1, 1, end_at);
    @(negedge iCLK) iFVAL = 1'b0;
    idle(3);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_npix"}, 64'(out_data.size()), 64'(in_data.size()));
    n = (out_data.size() < in_data.size()) ? out_data.size() : in_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(out_data[i]), 64'(in_data[i]));
      chk($sformatf("%s_x%0d", tag, i), 64'(out_x[i]), 64'(exp_x[i]));
      chk($sformatf("%s_y%0d", tag, i), 64'(out_y[i]), 64'(exp_y[i]));
      chk($sformatf("%s_lat%0d", tag, i), 64'(out_cyc[i] - in_cyc[i]), 64'd2);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  64'(oDATA), 64'd0);
    chk({tag, "_dval"},  64'(oDVAL), 64'd0);
    chk({tag, "_x"},     64'(oX_Cont), 64'd0);
    chk({tag, "_y"},     64'(oY_Cont), 64'd0);
    chk({tag, "_frame"}, 64'(oFrame_Cont), 64'd0);
    chk({tag, "_busy"},  64'(oBUSY), 64'd0);
  endtask

  initial begin
    iRST = 1'b0; iDATA = '0; iFVAL = 1'b0; iLVAL = 1'b0;
    iSTART = 1'b0; iEND = 1'b0;
    idle(3);
    check_zero("reset");
    iRST = 1'b1;
    idle(1);

    // Full 2x4 frame after a start pulse: data 1..8, (0,0)..(3,1)
    pulse_start();
    chk("armed_busy", 64'(oBUSY), 64'd1);
    clear_q();
    send_frame(4, 4, -1);
    check_frame("f1");
    chk("f1_count", 64'(oFrame_Cont), 64'd1);
    chk("f1_busy", 64'(oBUSY), 64'd1);

    // Stop requested at pixel 1 of frame 2: frame completes, then idle
    clear_q();
    send_frame(4, 4, 1);
    check_frame("f2stop");
    chk("f2stop_count", 64'(oFrame_Cont), 64'd2);
    chk("f2stop_busy", 64'(oBUSY), 64'd0);
    clear_q();
    send_frame(4, 4, -1);
    chk("f3_npix", 64'(out_data.size()), 64'd0);
    chk("f3_count", 64'(oFrame_Cont), 64'd2);

    // Start arriving mid-frame: rest of that frame ignored
    do_reset();
    clear_q();
    frame_idx = 0;
    @(negedge iCLK) iFVAL = 1'b1;
    idle(2);
    send_line(4, 0, -1);
    pulse_start();
    send_line(4, 1, -1);
    @(negedge iCLK) iFVAL = 1'b0;
    idle(3);
    chk("mid_npix", 64'(out_data.size()), 64'd0);
    chk("mid_busy", 64'(oBUSY), 64'd1);
    chk("mid_count", 64'(oFrame_Cont), 64'd0);
    clear_q();
    send_frame(4, 4, -1);
    check_frame("mid_next");
    chk("mid_next_count", 64'(oFrame_Cont), 64'd1);

    // Short line (3 px) followed by a full line
    clear_q();
    send_frame(3, 4, -1);
    check_frame("short");
    chk("short_count", 64'(oFrame_Cont), 64'd2);

    // Start and stop in the same cycle from idle
    do_reset();
    @(negedge iCLK);
    iSTART = 1'b1; iEND = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0; iEND = 1'b0;
    idle(1);
    chk("both_busy", 64'(oBUSY), 64'd0);
    clear_q();
    send_frame(4, 4, -1);
    chk("both_npix", 64'(out_data.size()), 64'd0);
    chk("both_count", 64'(oFrame_Cont), 64'd0);

    // Reset asserted while pixel (2,1) is on the output
    do_reset();
    pulse_start();
    clear_q();
    frame_idx = 0;
    @(negedge iCLK) iFVAL = 1'b1;
    idle(2);
    send_line(4, 0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      iLVAL = 1'b1;
      iDATA = PIX_W'(pix_val);
      pix_val++;
    end
    @(negedge iCLK);
    chk("rst_pre_dval", 64'(oDVAL), 64'd1);
    chk("rst_pre_x", 64'(oX_Cont), 64'd2);
    chk("rst_pre_y", 64'(oY_Cont), 64'd1);
    iRST = 1'b0;
    #1;
    check_zero("rst_mid");
    iLVAL = 1'b0;
    idle(2);
    iFVAL = 1'b0;
    idle(1);
    iRST = 1'b1;
    idle(1);
    clear_q();
    send_frame(4, 4, -1);
    send_frame(4, 4, -1);
    chk("post_rst_npix", 64'(out_data.size()), 64'd0);
    chk("post_rst_busy", 64'(oBUSY), 64'd0);
    chk("post_rst_count", 64'(oFrame_Cont), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_raw_capture
`default_nettype wire
